// File: rtl/tick_pkg.sv
// Shared types and defaults for the tick_scheduler timer block.
package tick_pkg;

    localparam int TICK_PRESCALE_DEF = 50000;
    localparam int TICK_CNT_W        = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ASSERT = 1'b1
    } irq_state_e;

    typedef struct packed {
        logic [TICK_CNT_W-1:0] period;
        logic                  en;
        logic                  periodic;
    } chan_cfg_t;

endpackage

// File: rtl/tick_channel.sv
// One timer channel: counts base ticks down from its period and flags expiry,
// then reloads (periodic) or disables itself (one-shot).
module tick_channel
    import tick_pkg::*;
#(
    parameter int CNT_W = TICK_CNT_W
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      base_tick,
    input  logic      wr,
    input  chan_cfg_t wr_cfg,
    output logic      expire,
    output logic      tick
);

    chan_cfg_t        cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wr_period;
    logic             tick_q, tick_d;

    assign wr_period = CNT_W'(wr_cfg.period);

    // A config write takes priority over a coincident base tick.
    always_comb begin
        cfg_d  = cfg_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (wr) begin
            cfg_d          = wr_cfg;
            cfg_d.en       = wr_cfg.en & (wr_period != '0);
            cnt_d          = wr_period;
        end else if (base_tick && cfg_q.en) begin
            if (cnt_q == CNT_W'(1)) begin
                tick_d = 1'b1;
                if (cfg_q.periodic) begin
                    cnt_d = CNT_W'(cfg_q.period);
                end else begin
                    cfg_d.en = 1'b0;
                    cnt_d    = '0;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign expire = tick_d;
    assign tick   = tick_q;

endmodule

// File: rtl/tick_scheduler.sv
// Prescaled multi-channel timer with round-robin interrupt arbitration.
// Optional sticky overrun flags are built when TICK_OVERRUN_EN is defined.
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CNT_W    = TICK_CNT_W,
    parameter int PRESCALE = TICK_PRESCALE_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [$clog2(NCH)-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic                    cfg_en,
    input  logic                    cfg_periodic,
    output logic                    irq,
    output logic [$clog2(NCH)-1:0]  irq_id,
    input  logic                    irq_ack,
    output logic [NCH-1:0]          tick_out,
    output logic [NCH-1:0]          pending
`ifdef TICK_OVERRUN_EN
    ,
    output logic [NCH-1:0]          overrun
`endif
);

    localparam int ID_W = $clog2(NCH);
    localparam int PW   = $clog2(PRESCALE);

    logic [PW-1:0]   presc_q, presc_d;
    logic            base_tick;
    logic [NCH-1:0]  pending_q, pending_d;
    logic [NCH-1:0]  wr_vec, expire_vec, clr_vec;
    chan_cfg_t       cfg_w;
    irq_state_e      state_q, state_d;
    logic [ID_W-1:0] irq_id_q, irq_id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [ID_W-1:0] rr_sel, rr_idx;
    logic            rr_found;

    assign base_tick = (presc_q == PW'(PRESCALE - 1));
    assign presc_d   = base_tick ? '0 : presc_q + PW'(1);

    always_comb begin
        cfg_w          = '0;
        cfg_w.period   = TICK_CNT_W'(cfg_period);
        cfg_w.en       = cfg_en;
        cfg_w.periodic = cfg_periodic;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign wr_vec[g] = cfg_we && (cfg_ch == ID_W'(g));
        tick_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .base_tick (base_tick),
            .wr        (wr_vec[g]),
            .wr_cfg    (cfg_w),
            .expire    (expire_vec[g]),
            .tick      (tick_out[g])
        );
    end

    // Round-robin pick: first pending channel after the last one granted.
    always_comb begin
        rr_sel   = last_grant_q;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            rr_idx = last_grant_q + ID_W'(i);
            if (!rr_found && pending_q[rr_idx]) begin
                rr_sel   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        irq_id_d     = irq_id_q;
        last_grant_d = last_grant_q;
        clr_vec      = '0;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    irq_id_d = rr_sel;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (irq_ack) begin
                    clr_vec[irq_id_q] = 1'b1;
                    last_grant_d      = irq_id_q;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq    = (state_q == ASSERT);
        irq_id = irq_id_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            irq_id_q     <= '0;
            last_grant_q <= ID_W'(NCH - 1);
        end else begin
            state_q      <= state_d;
            irq_id_q     <= irq_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // A new expiry outranks an acknowledge of the same channel.
    assign pending_d = (pending_q & ~clr_vec) | expire_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            pending_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

`ifdef TICK_OVERRUN_EN
    logic [NCH-1:0] overrun_q, overrun_d;

    assign overrun_d = (overrun_q & ~wr_vec) | (expire_vec & pending_q & ~clr_vec);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: directed and random configuration traffic
// against a timestamp-based reference model.
module tb_tick_scheduler;

    localparam int NCH   = 4;
    localparam int CNT_W = 32;
    localparam int PS    = 4;
    localparam int IDW   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [IDW-1:0]   cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_en;
    logic             cfg_periodic;
    logic             irq;
    logic [IDW-1:0]   irq_id;
    logic             irq_ack;
    logic [NCH-1:0]   tick_out;
    logic [NCH-1:0]   pending;
`ifdef TICK_OVERRUN_EN
    logic [NCH-1:0]   overrun;
`endif

    always #5 clk = ~clk;

    tick_scheduler #(.NCH(NCH), .CNT_W(CNT_W), .PRESCALE(PS)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_period   (cfg_period),
        .cfg_en       (cfg_en),
        .cfg_periodic (cfg_periodic),
        .irq          (irq),
        .irq_id       (irq_id),
        .irq_ack      (irq_ack),
        .tick_out     (tick_out),
        .pending      (pending)
`ifdef TICK_OVERRUN_EN
        ,
        .overrun      (overrun)
`endif
    );

    typedef struct {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] pend;
        logic           irq;
        logic [IDW-1:0] id;
        logic [NCH-1:0] ovr;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    // Reference model: each channel remembers the absolute edge of its next expiry.
    bit             m_act[NCH];
    bit             m_per[NCH];
    int             m_period[NCH];
    int             m_next[NCH];
    logic [NCH-1:0] m_pend;
    logic [NCH-1:0] m_ovr;
    bit             m_irq;
    int             m_id;
    int             m_last;
    int             k_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", name, act, exp, k_edge);
        end
    endtask

    function automatic int first_bt(input int k);
        int f;
        f = (k / PS) * PS + PS - 1;
        if (f <= k) f += PS;
        return f;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_act[c] = 1'b0; m_per[c] = 1'b0; m_period[c] = 0; m_next[c] = 0;
        end
        m_pend = '0; m_ovr = '0; m_irq = 1'b0; m_id = 0; m_last = NCH - 1; k_edge = 0;
    endtask

    function automatic bit auto_ack(input int pct);
        return m_irq && ($urandom_range(0, 99) < pct);
    endfunction

    // Called at a falling edge: drive one cycle of inputs, predict, wait for next falling edge.
    task automatic cycle(input bit we, input int ch, input int period, input bit en,
                         input bit per, input bit ack);
        logic [NCH-1:0] ex;
        logic [NCH-1:0] clr;
        bit             found;
        int             idx;
        exp_t           e;
        cfg_we = we; cfg_ch = ch[IDW-1:0]; cfg_period = period;
        cfg_en = en; cfg_periodic = per; irq_ack = ack;
        ex = '0; clr = '0;
        for (int c = 0; c < NCH; c++) begin
            if (we && ch == c) begin
                m_act[c]    = en && (period != 0);
                m_per[c]    = per;
                m_period[c] = period;
                m_next[c]   = first_bt(k_edge) + (period - 1) * PS;
                m_ovr[c]    = 1'b0;
            end else if (m_act[c] && m_next[c] == k_edge) begin
                ex[c] = 1'b1;
                if (m_per[c]) m_next[c] += m_period[c] * PS;
                else          m_act[c] = 1'b0;
            end
        end
        if (m_irq) begin
            if (ack) begin
                clr[m_id] = 1'b1; m_last = m_id; m_irq = 1'b0;
            end
        end else if (m_pend != '0) begin
            found = 1'b0;
            for (int i = 1; i <= NCH; i++) begin
                idx = (m_last + i) % NCH;
                if (!found && m_pend[idx]) begin
                    found = 1'b1; m_id = idx; m_irq = 1'b1;
                end
            end
        end
        m_ovr  = m_ovr | (ex & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | ex;
        e.tick = ex; e.pend = m_pend; e.irq = m_irq; e.id = m_id[IDW-1:0]; e.ovr = m_ovr;
        sb_q.push_back(e);
        k_edge++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input int ack_pct);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 1'b0, auto_ack(ack_pct));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_irq"}, 32'(irq), 32'd0);
        check({tag, "_irq_id"}, 32'(irq_id), 32'd0);
        check({tag, "_tick_out"}, 32'(tick_out), 32'd0);
        check({tag, "_pending"}, 32'(pending), 32'd0);
`ifdef TICK_OVERRUN_EN
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
`endif
    endtask

    // Reset asserted asynchronously in the middle of a low clock phase.
    task automatic reset_midrun();
        cfg_we = 1'b0; irq_ack = 1'b0;
        mon_en = 1'b0;
        sb_q.delete();
        #2 rst = 1'b0;
        #1 check_all_zero("midrst");
        repeat (3) @(negedge clk);
        check_all_zero("rst_hold");
        rst = 1'b1;
        model_reset();
        mon_en = 1'b1;
    endtask

    task automatic wait_model_irq(input string tag);
        int n;
        n = 0;
        while (!m_irq && n < 40) begin
            idle(1, 0);
            n++;
        end
        check({tag, "_irq_wait"}, 32'(m_irq), 32'd1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_empty: actual=no expectation required=one per cycle");
                end else begin
                    e = sb_q.pop_front();
                    check("tick_out", 32'(tick_out), 32'(e.tick));
                    check("pending", 32'(pending), 32'(e.pend));
                    check("irq", 32'(irq), 32'(e.irq));
                    if (e.irq) check("irq_id", 32'(irq_id), 32'(e.id));
`ifdef TICK_OVERRUN_EN
                    check("overrun", 32'(overrun), 32'(e.ovr));
`endif
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        rst = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        cfg_en = 1'b0; cfg_periodic = 1'b0; irq_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        mon_en = 1'b1;

        // Periodic channel 0, period 3: pulses every 12 clocks.
        cycle(1'b1, 0, 3, 1'b1, 1'b1, 1'b0);
        idle(60, 100);
        cycle(1'b1, 0, 0, 1'b1, 1'b1, 1'b0);
        idle(30, 100);

        // One-shot channel 1, period 2: held unacknowledged, then released.
        cycle(1'b1, 1, 2, 1'b1, 1'b0, 1'b0);
        idle(14, 0);
        idle(100, 100);

        // Config write landing on channel 0's expiring base tick.
        cycle(1'b1, 0, 2, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (m_next[0] != k_edge && n < 40) begin
            idle(1, 100);
            n++;
        end
        check("coincide_wait", 32'(m_next[0] == k_edge), 32'd1);
        cycle(1'b1, 0, 3, 1'b1, 1'b1, 1'b0);
        idle(40, 100);
        cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(20, 100);

        // Reset while an interrupt is outstanding.
        cycle(1'b1, 3, 1, 1'b1, 1'b0, 1'b0);
        wait_model_irq("pre_rst");
        reset_midrun();

        // Simultaneous expiries on channels 1 and 2, two rounds.
        for (int r = 0; r < 2; r++) begin
            while (k_edge % PS != 0) idle(1, 100);
            cycle(1'b1, 1, 1, 1'b1, 1'b0, 1'b0);
            cycle(1'b1, 2, 1, 1'b1, 1'b0, 1'b0);
            idle(20, 100);
        end

`ifdef TICK_OVERRUN_EN
        // Unacknowledged repeated expiry on channel 0, then cleared by a write.
        cycle(1'b1, 0, 1, 1'b1, 1'b1, 1'b0);
        idle(12, 0);
        cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
        idle(20, 100);
`endif

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0)
                cycle(1'b1, int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 6)),
                      ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), auto_ack(30));
            else
                idle(1, 30);
        end

        // Second mid-run reset followed by more random traffic.
        cycle(1'b1, 2, 1, 1'b1, 1'b1, 1'b0);
        wait_model_irq("pre_rst2");
        reset_midrun();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0)
                cycle(1'b1, int'($urandom_range(0, NCH - 1)), int'($urandom_range(1, 4)),
                      1'b1, 1'($urandom_range(0, 1)), auto_ack(50));
            else
                idle(1, 50);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
